instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/instr_fetch_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 widths, opcode constants and fetch datapath types.
// Imported by fetch_fifo and instr_fetch_unit.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [6:0] OPCODE_R     = 7'b0110011;
  localparam logic [6:0] OPCODE_I     = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    FS_RUN   = 1'b0,
    FS_DRAIN = 1'b1
  } fetch_state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO with flush, used for both the instruction buffer and the PC queue.
// A push on a full FIFO is accepted only when a pop frees a slot in the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       count
);

  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Slots are zeroed on reset so the head reads as all-zero while empty after reset.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    logic [WIDTH-1:0] slot_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_q <= '0;
      end else if (do_push && !flush && (wr_ptr_q == 1'(gi))) begin
        slot_q <= wdata;
      end
    end
  end

  assign rdata = rd_ptr_q ? g_slot[1].slot_q : g_slot[0].slot_q;
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: credit-limited request issue, in-order responses, redirect with drain.
// Define FETCH_PERF_CNT_EN to add the perf_stall_cnt / perf_flush_cnt counters.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [ILEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]     perf_stall_cnt,
  output logic [15:0]     perf_flush_cnt,
`endif
  output logic [6:0]      Opcode
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [1:0]      out_q, out_d;
  logic [1:0]      discard_q, discard_d;
  fetch_state_t    state_q, state_d;
  logic            live_q, live_d;

  logic            pop_id, resp, fire, deliver;
  logic [2:0]      inflight;
  fetch_entry_t    ibuf_wdata, ibuf_head;
  logic [1:0]      ibuf_count, pcq_count;
  logic [XLEN-1:0] pcq_head;

  assign id_valid  = (ibuf_count != 2'd0);
  assign id_instr  = ibuf_head.instr;
  assign id_pc     = ibuf_head.pc;
  assign Opcode    = ibuf_head.instr[6:0];
  assign imem_addr = pc_q;

  always_comb begin
    pop_id   = id_valid && id_ready;
    resp     = imem_rvalid && (out_q != 2'd0);
    // Counting the slot freed by this cycle's pop keeps one-per-cycle throughput
    // while outstanding + buffered can still never exceed the buffer depth.
    inflight = {1'b0, out_q} + {1'b0, ibuf_count} - {2'b00, pop_id};
    imem_req = live_q && !redirect_valid && (inflight < 3'd2);
    fire     = imem_req && imem_ready;
    deliver  = resp && !redirect_valid && (state_q == FS_RUN) && (pcq_count != 2'd0);

    ibuf_wdata.instr = imem_rdata;
    ibuf_wdata.pc    = pcq_head;

    live_d    = 1'b1;
    pc_d      = pc_q;
    out_d     = out_q + {1'b0, fire} - {1'b0, resp};
    discard_d = discard_q;
    if (redirect_valid) begin
      pc_d      = word_align(redirect_pc);
      discard_d = out_q - {1'b0, resp};
    end else begin
      if (fire) pc_d = pc_q + 32'd4;
      if ((state_q == FS_DRAIN) && resp && (discard_q != 2'd0)) begin
        discard_d = discard_q - 2'd1;
      end
    end
    state_d = (discard_d != 2'd0) ? FS_DRAIN : FS_RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      out_q     <= 2'd0;
      discard_q <= 2'd0;
      state_q   <= FS_RUN;
      live_q    <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      out_q     <= out_d;
      discard_q <= discard_d;
      state_q   <= state_d;
      live_q    <= live_d;
    end
  end

  fetch_fifo #(
    .WIDTH($bits(fetch_entry_t))
  ) u_ibuf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (deliver),
    .pop   (pop_id),
    .flush (redirect_valid),
    .wdata (ibuf_wdata),
    .rdata (ibuf_head),
    .count (ibuf_count)
  );

  // Holds addresses of requests whose responses will be delivered; discarded ones are not tracked.
  fetch_fifo #(
    .WIDTH(XLEN)
  ) u_pcq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fire),
    .pop   (deliver),
    .flush (redirect_valid),
    .wdata (pc_q),
    .rdata (pcq_head),
    .count (pcq_count)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic [15:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!id_valid && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
    if (redirect_valid && (flush_q != 16'hFFFF)) flush_d = flush_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 32'd0;
      flush_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign perf_stall_cnt = stall_q;
  assign perf_flush_cnt = flush_q;
`endif

endmodule
